// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reset_seq_pkg
//  Purpose  : Shared definitions for the reset sequencer slice. Holds the
//             sequencer state encoding and the default parameter values.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package reset_seq_pkg;

  // Default build parameters for the sequencer and its interface.
  localparam int DEF_N_DOMAINS   = 4;
  localparam int DEF_SYNC_STAGES = 3;
  localparam int DEF_DELAY_W     = 8;
  localparam int DEF_ACK_TIMEOUT = 255;

  // Sequencer state encoding. Values are fixed so that existing debug
  // tooling that decodes the raw state register keeps working.
  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_HOLD    = 3'd0;
  localparam seq_state_t ST_RELEASE = 3'd1;
  localparam seq_state_t ST_RUN     = 3'd2;
  localparam seq_state_t ST_QUIESCE = 3'd3;
  localparam seq_state_t ST_ASSERT  = 3'd4;

  // Number of bits needed to hold values 0..max_value (never less than 1).
  function automatic int bits_for(input int max_value);
    int w;
    w = 1;
    while ((max_value >> w) != 0) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reset_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : reset_sequencer_if
//  Purpose  : Bundles the configuration, warm-reset handshake and status
//             signals between the reset sequencer and the blocks it controls.
//  Ports    : delay_cfg    gap between releases / warm-reset hold time
//             sw_req       single-cycle warm-reset request
//             domain_ack   per-domain quiesce acknowledge (level)
//             domain_rst   per-domain reset, 1 = held in reset
//             quiesce_req  request for domains to drain
//             busy/done    sequencer status
//             timeout_flag sticky quiesce-timeout indication
//  Modports : master = sequencer side, slave = controlled-domain side
//  Revision : 1.0  initial release
// ============================================================================
interface reset_sequencer_if
  import reset_seq_pkg::*;
#(
  parameter int N_DOMAINS = DEF_N_DOMAINS,
  parameter int DELAY_W   = DEF_DELAY_W
);

  logic [DELAY_W-1:0]   delay_cfg;
  logic                 sw_req;
  logic [N_DOMAINS-1:0] domain_ack;
  logic [N_DOMAINS-1:0] domain_rst;
  logic                 quiesce_req;
  logic                 busy;
  logic                 done;
  logic                 timeout_flag;

  modport master (
    input  delay_cfg,
    input  sw_req,
    input  domain_ack,
    output domain_rst,
    output quiesce_req,
    output busy,
    output done,
    output timeout_flag
  );

  modport slave (
    output delay_cfg,
    output sw_req,
    output domain_ack,
    input  domain_rst,
    input  quiesce_req,
    input  busy,
    input  done,
    input  timeout_flag
  );

endinterface
`default_nettype wire

// File: rtl/reset_sequencer_sync.sv
`default_nettype none
// ============================================================================
//  Module   : reset_sync
//  Purpose  : Reset deassertion synchronizer. Output asserts asynchronously
//             with rst and deasserts on the STAGES-th rising clk edge after
//             rst falls.
//  Ports    : clk      block clock
//             rst      asynchronous active-high reset
//             rst_sync synchronized reset, asserted high
//  Revision : 1.0  initial release
// ============================================================================
module reset_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic rst_sync
);

  logic [STAGES-1:0] r_chain;

  // All stages are preset by rst; zeros walk in from bit 0 once rst drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chain <= '1;
    end else begin
      r_chain <= r_chain << 1;
    end
  end

  assign rst_sync = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : reset_sequencer
//  Purpose  : Orders reset release for N_DOMAINS downstream blocks. All
//             domain resets assert asynchronously with rst; after rst is
//             synchronized away they release one by one (domain 0 first)
//             with a programmable gap. A software warm reset quiesces the
//             domains, reasserts every reset and re-runs the release.
//  Ports    : clk  block clock
//             rst  asynchronous active-high reset
//             bus  reset_sequencer_if.master (delay_cfg, sw_req, domain_ack
//                  in; domain_rst, quiesce_req, busy, done, timeout_flag out)
//  Revision : 1.0  initial release
// ============================================================================
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_DOMAINS   = DEF_N_DOMAINS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DELAY_W     = DEF_DELAY_W,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  reset_sequencer_if.master bus
);

  localparam int IDX_W = (N_DOMAINS > 1) ? bits_for(N_DOMAINS - 1) : 1;
  localparam int ACK_W = bits_for(ACK_TIMEOUT);
  localparam int CNT_W = (DELAY_W > ACK_W) ? DELAY_W : ACK_W;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DOMAINS - 1);
  localparam logic [CNT_W-1:0] ACK_LOAD = CNT_W'(ACK_TIMEOUT);

  // The HOLD->RELEASE transition flop acts as the last synchronizer stage,
  // so the external chain is one stage shorter. Net effect: RELEASE is
  // entered on the SYNC_STAGES-th clk edge after rst falls.
  localparam int PRE_STAGES = (SYNC_STAGES > 1) ? (SYNC_STAGES - 1) : 1;

  seq_state_t           r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [CNT_W-1:0]     r_cnt;
  logic [N_DOMAINS-1:0] r_domain_rst;
  logic                 r_quiesce_req;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_timeout_flag;

  logic                 w_rst_pre;
  logic [CNT_W-1:0]     w_gap;
  logic                 w_all_ack;
  logic                 w_cnt_zero;

  reset_sync #(
    .STAGES (PRE_STAGES)
  ) u_reset_sync (
    .clk      (clk),
    .rst      (rst),
    .rst_sync (w_rst_pre)
  );

  assign w_gap      = CNT_W'(bus.delay_cfg);
  assign w_all_ack  = &bus.domain_ack;
  assign w_cnt_zero = (r_cnt == '0);

  // Every output is a flop; status bits are updated on the same edge as the
  // state change so busy/done never glitch relative to domain_rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_HOLD;
      r_idx          <= '0;
      r_cnt          <= '0;
      r_domain_rst   <= '1;
      r_quiesce_req  <= 1'b0;
      r_busy         <= 1'b1;
      r_done         <= 1'b0;
      r_timeout_flag <= 1'b0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (!w_rst_pre) begin
            r_state <= ST_RELEASE;
            r_idx   <= '0;
            r_cnt   <= w_gap;
          end
        end

        ST_RELEASE: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            // Clearing one bit per step in ascending index keeps the
            // "no higher domain out of reset before a lower one" invariant.
            r_domain_rst[r_idx] <= 1'b0;
            if (r_idx == LAST_IDX) begin
              r_state <= ST_RUN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
              r_cnt <= w_gap;
            end
          end
        end

        ST_RUN: begin
          r_domain_rst <= '0;
          if (bus.sw_req) begin
            r_state        <= ST_QUIESCE;
            r_quiesce_req  <= 1'b1;
            r_timeout_flag <= 1'b0;
            r_cnt          <= ACK_LOAD;
            r_busy         <= 1'b1;
            r_done         <= 1'b0;
          end
        end

        ST_QUIESCE: begin
          if (w_all_ack || w_cnt_zero) begin
            r_state       <= ST_ASSERT;
            r_quiesce_req <= 1'b0;
            r_domain_rst  <= '1;
            r_cnt         <= w_gap;
            // A full set of acks on the final count still counts as clean.
            if (!w_all_ack) begin
              r_timeout_flag <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        ST_ASSERT: begin
          if (w_cnt_zero) begin
            r_state <= ST_RELEASE;
            r_idx   <= '0;
            r_cnt   <= w_gap;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        default: begin
          // Unreachable encodings recover by restarting the cold sequence.
          r_state       <= ST_HOLD;
          r_idx         <= '0;
          r_cnt         <= '0;
          r_domain_rst  <= '1;
          r_quiesce_req <= 1'b0;
          r_busy        <= 1'b1;
          r_done        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.domain_rst   = r_domain_rst;
  assign bus.quiesce_req  = r_quiesce_req;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.timeout_flag = r_timeout_flag;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reset_sequencer
//  Purpose  : Self-checking bench for reset_sequencer. Stimulus computes the
//             expected output-change events (edge number + output values)
//             from the timing rules and queues them; a monitor compares each
//             observed output change against the queue head.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SS = 3;
  localparam int AT = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;

  reset_sequencer_if #(.N_DOMAINS(N), .DELAY_W(DW)) bus ();

  reset_sequencer #(
    .N_DOMAINS   (N),
    .SYNC_STAGES (SS),
    .DELAY_W     (DW),
    .ACK_TIMEOUT (AT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [N-1:0] drst;
    logic         q;
    logic         busy;
    logic         done;
    logic         tflag;
  } ev_t;

  ev_t          exp_q[$];
  int           cyc = 0;
  int           errors = 0;
  int           checks = 0;
  logic         model_tflag = 1'b0;
  logic [N+3:0] prev = {{N{1'b1}}, 1'b0, 1'b1, 1'b0, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N+3:0] evpack(input ev_t e);
    return {e.drst, e.q, e.busy, e.done, e.tflag};
  endfunction

  // Monitor: every output change must match the next queued event, and the
  // release-ordering invariant must hold on every cycle.
  always @(negedge clk) begin
    logic [N+3:0] cur;
    logic [N:0]   rel;
    ev_t          e;
    cur = {bus.domain_rst, bus.quiesce_req, bus.busy, bus.done, bus.timeout_flag};
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_event now=%0d exp_cyc=%0d exp=%b", cyc, e.cyc, evpack(e));
    end
    if (cur !== prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d got=%b was=%b", cyc, cur, prev);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || evpack(e) !== cur) begin
          errors++;
          $display("FAIL event got_cyc=%0d got=%b exp_cyc=%0d exp=%b", cyc, cur, e.cyc, evpack(e));
        end
      end
    end
    rel = {1'b0, ~bus.domain_rst};
    checks++;
    if (((rel + 1'b1) & rel) != '0) begin
      errors++;
      $display("FAIL release_order cyc=%0d domain_rst=%b", cyc, bus.domain_rst);
    end
    prev = cur;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_ev(input int c, input logic [N-1:0] drst, input logic q,
                         input logic busy, input logic done, input logic tflag);
    ev_t e;
    e.cyc = c; e.drst = drst; e.q = q; e.busy = busy; e.done = done; e.tflag = tflag;
    exp_q.push_back(e);
  endtask

  // Release i (0-based) happens (d+1)*(i+1) edges after RELEASE entry r.
  task automatic push_release(input int r, input int d, output int last);
    logic [N-1:0] ones;
    ones = '1;
    for (int i = 0; i < N; i++) begin
      push_ev(r + (d + 1) * (i + 1), ones << (i + 1), 1'b0,
              (i != N - 1), (i == N - 1), model_tflag);
    end
    last = r + (d + 1) * N;
  endtask

  function automatic logic [N-1:0] partial_ack();
    logic [N-1:0] v;
    v = N'($urandom);
    if (&v) v[0] = 1'b0;
    return v;
  endfunction

  // Asynchronous reset injection while outputs differ from reset values.
  task automatic inject_rst();
    rst = 1'b1;
    exp_q.delete();
    model_tflag = 1'b0;
    push_ev(cyc, '1, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("async_domain_rst", 32'(bus.domain_rst), 32'({N{1'b1}}));
    chk("async_quiesce_req", 32'(bus.quiesce_req), 32'd0);
    tick(2);
  endtask

  // Cold release from rst drop. ignore_sw pulses sw_req during HOLD and
  // RELEASE; rst_at >= 0 re-asserts rst that many edges after the drop.
  task automatic do_cold(input int d, input bit ignore_sw, input int rst_at);
    int c0, last, gap;
    bus.delay_cfg = DW'(d);
    c0 = cyc;
    model_tflag = 1'b0;
    push_release(c0 + SS, d, last);
    rst = 1'b0;
    gap = 0;
    while (cyc < last + 2) begin
      if (rst_at >= 0 && cyc == c0 + rst_at) begin
        inject_rst();
        return;
      end
      bus.sw_req = 1'b0;
      if (ignore_sw && cyc + 1 <= last) begin
        if (gap == 0) begin
          bus.sw_req = 1'b1;
          gap = $urandom_range(1, d + 2);
        end else begin
          gap--;
        end
      end
      tick(1);
    end
    bus.sw_req = 1'b0;
    chk("cold_done", 32'(bus.done), 32'd1);
  endtask

  // Warm reset from RUN. ack_after < 0: acks never complete. rst_after >= 0
  // re-asserts rst that many edges into QUIESCE (must be before exit).
  task automatic do_warm(input int d, input int ack_after, input logic [N-1:0] idle_ack,
                         input int rst_after);
    int e, ack_edge, x, last;
    bus.delay_cfg = DW'(d);
    bus.domain_ack = idle_ack;
    bus.sw_req = 1'b1;
    e = cyc + 1;
    ack_edge = (ack_after >= 0) ? e + ack_after + 1 : 32'h7fff_ffff;
    x = (ack_edge < e + 1 + AT) ? ack_edge : e + 1 + AT;
    model_tflag = 1'b0;
    push_ev(e, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    if (ack_edge > x) model_tflag = 1'b1;
    push_ev(x, '1, 1'b0, 1'b1, 1'b0, model_tflag);
    push_release(x + d + 1, d, last);
    tick(1);
    bus.sw_req = 1'b0;
    while (cyc < last + 2) begin
      if (rst_after >= 0 && cyc == e + rst_after) begin
        inject_rst();
        return;
      end
      if (ack_after >= 0 && cyc == e + ack_after) bus.domain_ack = '1;
      tick(1);
    end
    chk("warm_timeout_flag", 32'(bus.timeout_flag), 32'(model_tflag));
    chk("warm_done", 32'(bus.done), 32'd1);
  endtask

  initial begin
    int d, op, r;
    bus.delay_cfg  = DW'(2);
    bus.sw_req     = 1'b0;
    bus.domain_ack = '0;
    #1 rst = 1'b1;
    tick(3);

    chk("reset_domain_rst", 32'(bus.domain_rst), 32'({N{1'b1}}));
    chk("reset_quiesce_req", 32'(bus.quiesce_req), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd1);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_timeout_flag", 32'(bus.timeout_flag), 32'd0);

    do_cold(2, 1'b0, -1);                       // cold release, gap 2
    do_warm(2, 5, 4'b0101, -1);                 // warm reset, acks after 5
    do_warm(3, -1, 4'b0111, -1);                // ack timeout
    chk("timeout_sticky", 32'(bus.timeout_flag), 32'd1);
    do_warm(1, AT, 4'b0011, -1);                // ack on the final count
    do_warm(0, 0, 4'b0000, -1);                 // ack immediately, zero gap
    inject_rst();
    do_cold(0, 1'b0, -1);                       // zero gap cold release
    inject_rst();
    do_cold(2, 1'b0, SS + 2 * 3);               // reset with domain_rst=1100
    do_cold(2, 1'b1, -1);                       // ignored sw_req pulses
    do_warm(2, -1, 4'b0111, 3);                 // reset mid-QUIESCE
    do_cold(1, 1'b0, -1);

    for (int it = 0; it < 24; it++) begin
      d  = $urandom_range(0, 4);
      op = $urandom_range(0, 3);
      if (op == 0) begin
        inject_rst();
        r = $urandom_range(0, 1) ? -1 : SS + (d + 1) * $urandom_range(1, N);
        do_cold(d, 1'($urandom_range(0, 1)), r);
        if (r >= 0) do_cold(d, 1'b0, -1);
      end else begin
        r = $urandom_range(0, 12) - 1;
        do_warm(d, r, partial_ack(), (op == 3) ? $urandom_range(0, 1) : -1);
        if (op == 3) do_cold(d, 1'b0, -1);
      end
    end

    tick(3);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d pending=%0d", cyc, exp_q.size());
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
